// File: rtl/bus_mux_arb.sv
// Parametrised N-to-1 bus multiplexer with registered output.
// Direct-select mode plus round-robin arbitration with an optional ownership lock.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

module bus_mux_arb #(
  parameter int SIGNAL_WIDTH = `REG_WIDTH,
  parameter int CHANNELS     = 8,
  parameter int SEL_WIDTH    = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CHANNELS*SIGNAL_WIDTH-1:0] in_bus,
  input  logic                             mode,
  input  logic [SEL_WIDTH-1:0]             selector,
  input  logic [CHANNELS-1:0]              req,
  input  logic                             lock,
  output logic [SIGNAL_WIDTH-1:0]          out,
  output logic                             out_valid,
  output logic [CHANNELS-1:0]              grant,
  output logic [SEL_WIDTH-1:0]             grant_idx
);

  localparam int SLOTS = 1 << SEL_WIDTH;
  localparam logic [SEL_WIDTH:0] CH_W = (SEL_WIDTH+1)'(CHANNELS);

  typedef enum logic {IDLE, OWN} state_t;

  // Channel table padded to the full selector range; unused slots read as zero.
  logic [SIGNAL_WIDTH-1:0] chan [SLOTS];

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_chan
    if (gi < CHANNELS) begin : g_live
      assign chan[gi] = in_bus[gi*SIGNAL_WIDTH +: SIGNAL_WIDTH];
    end else begin : g_pad
      assign chan[gi] = '0;
    end
  end

  state_t                  state_q, state_d;
  logic [SIGNAL_WIDTH-1:0] out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic [CHANNELS-1:0]     grant_q, grant_d;
  logic [SEL_WIDTH-1:0]    grant_idx_q, grant_idx_d;
  logic [SEL_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic                    mode_q, mode_d;
  logic                    mode_seen_q, mode_seen_d;

  logic                    mode_change;
  logic                    owner_req;
  logic                    sel_legal;
  logic [CHANNELS-1:0]     search_req;
  logic [2*CHANNELS-1:0]   search_rot;
  logic                    pick_found;
  logic [SEL_WIDTH:0]      pick_off;
  logic [SEL_WIDTH:0]      pick_sum;
  logic [SEL_WIDTH-1:0]    pick_idx;
  logic                    take;
  logic [SEL_WIDTH-1:0]    take_idx;
  logic [SEL_WIDTH:0]      take_next;

  // The first edge after reset never counts as a mode change.
  assign mode_change = mode_seen_q && (mode != mode_q);
  assign owner_req   = |(req & grant_q);
  assign sel_legal   = ({1'b0, selector} < CH_W);
  assign search_req  = (state_q == OWN) ? (req & ~grant_q) : req;
  assign search_rot  = {search_req, search_req} >> rr_ptr_q;
  assign pick_found  = |search_rot[CHANNELS-1:0];

  always_comb begin
    pick_off = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (search_rot[i]) pick_off = (SEL_WIDTH+1)'(i);
    end
    pick_sum = {1'b0, rr_ptr_q} + pick_off;
    if (pick_sum >= CH_W) pick_sum = pick_sum - CH_W;
    pick_idx = pick_sum[SEL_WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    mode_d      = mode;
    mode_seen_d = 1'b1;
    take        = 1'b0;
    take_idx    = grant_idx_q;
    take_next   = '0;

    if (mode_change) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      grant_d     = '0;
    end else if (!mode) begin
      state_d = IDLE;
      if (sel_legal) begin
        out_d       = chan[selector];
        out_valid_d = 1'b1;
        grant_d     = {{(CHANNELS-1){1'b0}}, 1'b1} << selector;
        grant_idx_d = selector;
      end else begin
        out_d       = '0;
        out_valid_d = 1'b0;
        grant_d     = '0;
      end
    end else begin
      if (state_q == OWN && lock && owner_req) begin
        out_d = chan[grant_idx_q];
      end else if (pick_found) begin
        take     = 1'b1;
        take_idx = pick_idx;
      end else if (state_q == OWN && owner_req) begin
        take     = 1'b1;
        take_idx = grant_idx_q;
      end else begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        grant_d     = '0;
      end

      if (take) begin
        take_next   = {1'b0, take_idx} + 1'b1;
        state_d     = OWN;
        out_d       = chan[take_idx];
        out_valid_d = 1'b1;
        grant_d     = {{(CHANNELS-1){1'b0}}, 1'b1} << take_idx;
        grant_idx_d = take_idx;
        rr_ptr_d    = (take_next == CH_W) ? '0 : take_next[SEL_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      mode_q      <= 1'b0;
      mode_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      mode_q      <= mode_d;
      mode_seen_q <= mode_seen_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_bus_mux_arb.sv
// Bench for bus_mux_arb: an 8-channel and a 6-channel instance share stimulus
// and are compared every cycle against a behavioural arbitration model.
module tb_bus_mux_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_bus;
  logic        mode;
  logic [2:0]  selector;
  logic [7:0]  req;
  logic        lock;

  logic [7:0]  out8;
  logic        v8;
  logic [7:0]  g8;
  logic [2:0]  gi8;
  logic [7:0]  out6;
  logic        v6;
  logic [5:0]  g6;
  logic [2:0]  gi6;

  always #5 clk = ~clk;

  bus_mux_arb #(.SIGNAL_WIDTH(8), .CHANNELS(8), .SEL_WIDTH(3)) dut8 (
    .clk(clk), .reset(reset), .in_bus(in_bus), .mode(mode), .selector(selector),
    .req(req), .lock(lock), .out(out8), .out_valid(v8), .grant(g8), .grant_idx(gi8)
  );

  bus_mux_arb #(.SIGNAL_WIDTH(8), .CHANNELS(6), .SEL_WIDTH(3)) dut6 (
    .clk(clk), .reset(reset), .in_bus(in_bus[47:0]), .mode(mode), .selector(selector),
    .req(req[5:0]), .lock(lock), .out(out6), .out_valid(v6), .grant(g6), .grant_idx(gi6)
  );

  int checks   = 0;
  int failures = 0;

  // Model state per instance: index 0 = 8 channels, index 1 = 6 channels.
  int nch     [2] = '{8, 6};
  int m_out   [2];
  int m_valid [2];
  int m_grant [2];
  int m_idx   [2];
  int m_ptr   [2];
  int m_owner [2];
  int m_prev  [2];
  int m_seen  [2];

  int rr_seq  [6] = '{0, 2, 3, 0, 2, 3};
  int lock_val[4] = '{'h99, 'h5A, 'h33, 'h77};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ch(input int k);
    return int'(in_bus[k*8 +: 8]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_out[d] = 0; m_valid[d] = 0; m_grant[d] = -1; m_idx[d] = 0;
      m_ptr[d] = 0; m_owner[d] = -1; m_prev[d] = 0; m_seen[d] = 0;
    end
  endtask

  task automatic model_give(input int d, input int x);
    m_owner[d] = x; m_grant[d] = x; m_idx[d] = x; m_out[d] = ch(x);
    m_valid[d] = 1; m_ptr[d] = (x + 1) % nch[d];
  endtask

  task automatic model_edge();
    int n, o, w, c;
    bit oreq;
    for (int d = 0; d < 2; d++) begin
      n = nch[d];
      if (m_seen[d] != 0 && int'(mode) != m_prev[d]) begin
        m_valid[d] = 0; m_grant[d] = -1; m_owner[d] = -1;
      end else if (!mode) begin
        m_owner[d] = -1;
        if (int'(selector) < n) begin
          m_out[d] = ch(int'(selector)); m_valid[d] = 1;
          m_grant[d] = int'(selector); m_idx[d] = int'(selector);
        end else begin
          m_out[d] = 0; m_valid[d] = 0; m_grant[d] = -1;
        end
      end else begin
        o    = m_owner[d];
        oreq = (o >= 0) && req[o];
        w    = -1;
        for (int s = 0; s < n; s++) begin
          c = (m_ptr[d] + s) % n;
          if (w < 0 && req[c] && c != o) w = c;
        end
        if (o >= 0 && lock && oreq) m_out[d] = ch(o);
        else if (w >= 0) model_give(d, w);
        else if (oreq) model_give(d, o);
        else begin
          m_owner[d] = -1; m_valid[d] = 0; m_grant[d] = -1;
        end
      end
      m_seen[d] = 1;
      m_prev[d] = int'(mode);
    end
  endtask

  function automatic logic [31:0] onehot(input int g);
    return (g < 0) ? 32'd0 : (32'd1 << g);
  endfunction

  task automatic compare_all();
    chk("d8_out",   32'(out8), 32'(m_out[0]));
    chk("d8_valid", 32'(v8),   32'(m_valid[0]));
    chk("d8_grant", 32'(g8),   onehot(m_grant[0]));
    chk("d8_idx",   32'(gi8),  32'(m_idx[0]));
    chk("d6_out",   32'(out6), 32'(m_out[1]));
    chk("d6_valid", 32'(v6),   32'(m_valid[1]));
    chk("d6_grant", 32'(g6),   onehot(m_grant[1]));
    chk("d6_idx",   32'(gi6),  32'(m_idx[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    compare_all();
    $display("t=%0t rst=%0d mode=%0d sel=%0d req=%h lock=%0d | d8 out=%h v=%0d g=%h i=%0d | d6 out=%h v=%0d g=%h i=%0d",
             $time, reset, mode, selector, req, lock, out8, v8, g8, gi8, out6, v6, g6, gi6);
  endtask

  // Reset asserted and released between edges; outputs must clear immediately.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; selector = '0; req = '0; lock = 1'b0;
    for (int k = 0; k < 8; k++) in_bus[k*8 +: 8] = 8'(8'h10 + k);
    model_reset();
    tick();
    tick();
    chk("rst_out", 32'(out8), 32'h0);
    chk("rst_grant", 32'(g8), 32'h0);
    reset = 1'b0;

    selector = 3'd5;
    tick();
    chk("dir5_out", 32'(out8), 32'h15);
    chk("dir5_grant", 32'(g8), 32'h20);
    chk("dir5_idx", 32'(gi8), 32'd5);
    chk("dir5_valid", 32'(v8), 32'd1);

    async_reset();
    chk("arst_out", 32'(out8), 32'h0);
    chk("arst_valid", 32'(v8), 32'h0);
    tick();

    selector = 3'd7;
    tick();
    chk("ill7_out", 32'(out6), 32'h0);
    chk("ill7_valid", 32'(v6), 32'h0);
    chk("ill7_grant", 32'(g6), 32'h0);
    selector = 3'd5;
    tick();
    chk("sel5_out6", 32'(out6), 32'h15);
    chk("sel5_valid6", 32'(v6), 32'd1);

    mode = 1'b1; req = 8'h0D; lock = 1'b0;
    tick();
    chk("rr_bubble", 32'(v8), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_seq_idx", 32'(gi8), 32'(rr_seq[i]));
      chk("rr_seq_valid", 32'(v8), 32'd1);
    end

    req = 8'h03; lock = 1'b1;
    tick();
    chk("lock_first", 32'(g8), 32'h01);
    for (int i = 0; i < 4; i++) begin
      in_bus[7:0] = 8'(lock_val[i]);
      tick();
      chk("lock_grant", 32'(g8), 32'h01);
      chk("lock_out", 32'(out8), 32'(lock_val[i]));
    end
    lock = 1'b0;
    tick();
    chk("unlock_grant", 32'(g8), 32'h02);

    req = 8'h00;
    tick();
    chk("rel_valid", 32'(v8), 32'd0);
    chk("rel_hold", 32'(out8), 32'h11);
    mode = 1'b0; selector = 3'd2;
    tick();
    chk("msw_bubble", 32'(v8), 32'd0);
    tick();
    chk("msw_out", 32'(out8), 32'h12);

    mode = 1'b1; req = 8'h08;
    tick();
    tick();
    chk("own3_idx", 32'(gi8), 32'd3);
    async_reset();
    chk("arst_mid_grant", 32'(g8), 32'h0);
    req = 8'hFF;
    tick();
    chk("post_rst_idx", 32'(gi8), 32'd0);
    chk("post_rst_valid", 32'(v8), 32'd1);

    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      selector = 3'($urandom_range(0, 7));
      req      = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req = '0;
      lock     = 1'($urandom_range(0, 1));
      in_bus   = {$urandom, $urandom};
      if ($urandom_range(0, 49) == 0) async_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
